episode_scheduler: RTL and testbench

Sequencing controller for the grid-world Q-learning datapath. It runs episodes on the 5x5 grid state tracker (states 1..25). Each step it picks an action with epsilon-greedy selection from an 8-bit LFSR, tells the state tracker to move, and waits on the Q-update unit through a req/ack handshake. It then checks for goal or step limit and restarts the episode through `change_iteration`. It sits between the top-level start/done control and the state tracker / Q-table update pipeline.

---
 rtl/episode_scheduler_if.sv | 27 ++
 rtl/episode_scheduler.sv | 124 ++++++++++++
 tb/tb_episode_scheduler.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/episode_scheduler_if.sv
// Control/handshake bundle between the episode scheduler and the grid tracker / Q-update pipeline.
// master = scheduler side, slave = tracker, Q-table and run-control side.
interface episode_scheduler_if;
    logic       start;
    logic [4:0] curr_state;
    logic [1:0] greedy_act;
    logic       upd_ack;
    logic [1:0] act;
    logic       act_valid;
    logic       change_iteration;
    logic       upd_req;
    logic       goal_hit;
    logic       busy;
    logic       done;
    logic [7:0] episode;
    logic [7:0] step;

    modport master (
        input  start, curr_state, greedy_act, upd_ack,
        output act, act_valid, change_iteration, upd_req, goal_hit, busy, done, episode, step
    );

    modport slave (
        output start, curr_state, greedy_act, upd_ack,
        input  act, act_valid, change_iteration, upd_req, goal_hit, busy, done, episode, step
    );
endinterface

// File: rtl/episode_scheduler.sv
// Epsilon-greedy episode sequencer for the grid-world Q-learning datapath; all outputs registered.
// Min 4 cycles per step (+1 on episode end); stalls in UPDATE while upd_ack is low.
module episode_scheduler #(
    parameter int unsigned MAX_EPISODES = 16,
    parameter int unsigned MAX_STEPS    = 32,
    parameter logic [4:0]  GOAL_STATE   = 5'd25,
    parameter logic [7:0]  EPS_THRESH   = 8'd26,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input logic                 clk,
    input logic                 rst,
    episode_scheduler_if.master sch
);
    localparam logic [7:0] MAX_EP_L = 8'(MAX_EPISODES);
    localparam logic [7:0] MAX_ST_L = 8'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SELECT, S_MOVE, S_UPDATE, S_CHECK, S_RESTART, S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d, lfsr_nxt;
    logic [1:0] act_q, act_d;
    logic [7:0] step_q, step_d;
    logic [7:0] episode_q, episode_d;
    logic       goal_q, goal_d;
    logic       act_valid_q, act_valid_d;
    logic       chg_q, chg_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        act_d     = act_q;
        step_d    = step_q;
        episode_d = episode_q;
        goal_d    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (sch.start) begin
                    state_d   = S_INIT;
                    step_d    = 8'd0;
                    episode_d = 8'd0;
                end
            end
            S_INIT: state_d = S_SELECT;
            S_SELECT: begin
                lfsr_d  = lfsr_nxt;
                act_d   = (lfsr_nxt < EPS_THRESH) ? lfsr_nxt[1:0] : sch.greedy_act;
                state_d = S_MOVE;
            end
            S_MOVE: state_d = S_UPDATE;
            S_UPDATE: begin
                // Tracker has already registered the move, so the goal test is made
                // here and the pulse lands in the CHECK cycle.
                if (sch.upd_ack) begin
                    step_d  = step_q + 8'd1;
                    goal_d  = (sch.curr_state == GOAL_STATE);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (goal_q || (step_q == MAX_ST_L)) begin
                    step_d    = 8'd0;
                    episode_d = episode_q + 8'd1;
                    state_d   = S_RESTART;
                end else begin
                    state_d = S_SELECT;
                end
            end
            S_RESTART: state_d = (episode_q == MAX_EP_L) ? S_DONE : S_SELECT;
            default: state_d = S_IDLE;
        endcase

        act_valid_d = (state_d == S_MOVE);
        chg_d       = (state_d == S_INIT) || (state_d == S_RESTART);
        req_d       = (state_d == S_UPDATE);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            act_q       <= 2'd0;
            step_q      <= 8'd0;
            episode_q   <= 8'd0;
            goal_q      <= 1'b0;
            act_valid_q <= 1'b0;
            chg_q       <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            act_q       <= act_d;
            step_q      <= step_d;
            episode_q   <= episode_d;
            goal_q      <= goal_d;
            act_valid_q <= act_valid_d;
            chg_q       <= chg_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sch.act              = act_q;
    assign sch.act_valid        = act_valid_q;
    assign sch.change_iteration = chg_q;
    assign sch.upd_req          = req_q;
    assign sch.goal_hit         = goal_q;
    assign sch.busy             = busy_q;
    assign sch.done             = done_q;
    assign sch.episode          = episode_q;
    assign sch.step             = step_q;
endmodule

// File: tb/tb_episode_scheduler.sv
// Bench for episode_scheduler: four parameterisations, grid tracker model, expected-move scoreboard.
module tb_episode_scheduler;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct packed {
        logic [1:0] act;
        logic [7:0] step;
    } exp_t;
    exp_t sb[$];

    episode_scheduler_if if_g ();
    episode_scheduler_if if_o ();
    episode_scheduler_if if_x ();
    episode_scheduler_if if_c ();

    episode_scheduler #(.MAX_EPISODES(16), .MAX_STEPS(6), .GOAL_STATE(5'd25),
                        .EPS_THRESH(8'd0), .LFSR_SEED(8'hA5))
        u_g (.clk(clk), .rst(rst), .sch(if_g));
    episode_scheduler #(.MAX_EPISODES(16), .MAX_STEPS(32), .GOAL_STATE(5'd25),
                        .EPS_THRESH(8'd0), .LFSR_SEED(8'hA5))
        u_o (.clk(clk), .rst(rst), .sch(if_o));
    episode_scheduler #(.MAX_EPISODES(16), .MAX_STEPS(32), .GOAL_STATE(5'd25),
                        .EPS_THRESH(8'hFF), .LFSR_SEED(8'hA5))
        u_x (.clk(clk), .rst(rst), .sch(if_x));
    episode_scheduler #(.MAX_EPISODES(2), .MAX_STEPS(1), .GOAL_STATE(5'd25),
                        .EPS_THRESH(8'd0), .LFSR_SEED(8'hA5))
        u_c (.clk(clk), .rst(rst), .sch(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 5x5 grid, state 1 top-left, row-major; moves off the edge leave the position unchanged
    function automatic logic [4:0] next_pos(input logic [4:0] p, input logic [1:0] a);
        int q;
        int col;
        q   = int'(p) - 1;
        col = q % 5;
        case (a)
            2'd0:    return (col < 4) ? p + 5'd1 : p;
            2'd1:    return (q >= 5)  ? p - 5'd5 : p;
            2'd2:    return (col > 0) ? p - 5'd1 : p;
            default: return (q < 20)  ? p + 5'd5 : p;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    logic [4:0] pos_g, pos_o;
    int         mv_o;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_g <= 5'd1;
            pos_o <= 5'd1;
            mv_o  <= 0;
        end else begin
            if (if_g.change_iteration)  pos_g <= 5'd1;
            else if (if_g.act_valid)    pos_g <= next_pos(pos_g, if_g.act);
            if (if_o.change_iteration) begin
                pos_o <= 5'd1;
                mv_o  <= 0;
            end else if (if_o.act_valid) begin
                pos_o <= next_pos(pos_o, if_o.act);
                mv_o  <= mv_o + 1;
            end
        end
    end

    assign if_g.curr_state = pos_g;
    assign if_g.greedy_act = 2'd0;
    assign if_g.upd_ack    = 1'b1;
    assign if_o.curr_state = pos_o;
    assign if_o.greedy_act = (mv_o < 4) ? 2'd0 : 2'd3;
    assign if_x.curr_state = 5'd1;
    assign if_x.greedy_act = 2'd3;
    assign if_x.upd_ack    = 1'b1;
    assign if_c.curr_state = 5'd1;
    assign if_c.greedy_act = 2'd0;

    task automatic test_reset();
        rst = 1'b0;
        if_g.start = 1'b0; if_o.start = 1'b0; if_x.start = 1'b0; if_c.start = 1'b0;
        if_o.upd_ack = 1'b1; if_c.upd_ack = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({if_g.act, if_g.act_valid, if_g.change_iteration, if_g.upd_req, if_g.goal_hit,
             if_g.busy, if_g.done} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0", {if_g.act, if_g.act_valid,
                     if_g.change_iteration, if_g.upd_req, if_g.goal_hit, if_g.busy, if_g.done});
        end
        n_checks++;
        if ({if_g.episode, if_g.step} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: episode %0d step %0d required 0 0", if_g.episode, if_g.step);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (if_g.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy %b required 0", if_g.busy);
        end
    endtask

    task automatic test_start_timing();
        if_g.start = 1'b1;
        @(negedge clk);
        if_g.start = 1'b0;
        n_checks++;
        if (if_g.change_iteration !== 1'b1 || if_g.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_init: chg %b busy %b required 1 1", if_g.change_iteration, if_g.busy);
        end
        @(negedge clk);
        n_checks++;
        if (if_g.change_iteration !== 1'b0 || if_g.act_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_select: chg %b act_valid %b required 0 0", if_g.change_iteration, if_g.act_valid);
        end
        @(negedge clk);
        n_checks++;
        if (if_g.act_valid !== 1'b1 || if_g.act !== 2'd0 || if_g.step !== 8'd0) begin
            n_fail++;
            $display("FAIL start_move: act_valid %b act %0d step %0d required 1 0 0",
                     if_g.act_valid, if_g.act, if_g.step);
        end
    endtask

    task automatic test_greedy_path();
        logic [7:0] prev_step;
        bit         seen;
        exp_t       e;
        seen      = 1'b0;
        prev_step = 8'd0;
        for (int i = 1; i < 6; i++) sb.push_back('{act: 2'd0, step: 8'(i)});
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (if_g.act_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL greedy_extra_move: step %0d required no move", if_g.step);
                end else begin
                    e = sb.pop_front();
                    if (if_g.act !== e.act || if_g.step !== e.step) begin
                        n_fail++;
                        $display("FAIL greedy_move: act %0d step %0d required %0d %0d",
                                 if_g.act, if_g.step, e.act, e.step);
                    end
                end
            end
            if (if_g.change_iteration) begin
                seen = 1'b1;
                n_checks++;
                if (prev_step !== 8'd6 || sb.size() != 0) begin
                    n_fail++;
                    $display("FAIL greedy_limit: last step %0d pending %0d required 6 0", prev_step, sb.size());
                end
                n_checks++;
                if (if_g.episode !== 8'd1 || if_g.step !== 8'd0 || if_g.goal_hit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL greedy_restart: episode %0d step %0d goal %b required 1 0 0",
                             if_g.episode, if_g.step, if_g.goal_hit);
                end
            end
            prev_step = if_g.step;
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL greedy_timeout: no restart seen required one");
        end
        if_g.start = 1'b1;
        @(negedge clk);
        if_g.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if_g.episode !== 8'd1 || if_g.change_iteration !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy: episode %0d chg %b required 1 0", if_g.episode, if_g.change_iteration);
        end
        sb.delete();
    endtask

    task automatic test_goal();
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) sb.push_back('{act: (i < 4) ? 2'd0 : 2'd3, step: 8'(i)});
        if_o.start = 1'b1;
        @(negedge clk);
        if_o.start = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (if_o.act_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL goal_extra_move: step %0d required no move", if_o.step);
                end else begin
                    e = sb.pop_front();
                    if (if_o.act !== e.act || if_o.step !== e.step) begin
                        n_fail++;
                        $display("FAIL goal_move: act %0d step %0d required %0d %0d",
                                 if_o.act, if_o.step, e.act, e.step);
                    end
                end
            end
            if (if_o.goal_hit) begin
                seen = 1'b1;
                n_checks++;
                if (if_o.step !== 8'd8 || sb.size() != 0 || if_o.change_iteration !== 1'b0) begin
                    n_fail++;
                    $display("FAIL goal_check: step %0d pending %0d chg %b required 8 0 0",
                             if_o.step, sb.size(), if_o.change_iteration);
                end
                @(negedge clk);
                n_checks++;
                if (if_o.change_iteration !== 1'b1 || if_o.goal_hit !== 1'b0 || if_o.episode !== 8'd1) begin
                    n_fail++;
                    $display("FAIL goal_restart: chg %b goal %b episode %0d required 1 0 1",
                             if_o.change_iteration, if_o.goal_hit, if_o.episode);
                end
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL goal_timeout: goal_hit never seen required one pulse");
        end
        sb.delete();
    endtask

    task automatic test_ack_stall();
        int n;
        if_o.upd_ack = 1'b0;
        for (int c = 0; c < 20 && !if_o.upd_req; c++) @(negedge clk);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (!if_o.upd_req) break;
            n++;
            n_checks++;
            if (if_o.act !== 2'd0 || if_o.step !== 8'd0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d act %0d step %0d required 0 0", n, if_o.act, if_o.step);
            end
            if (n == 6) if_o.upd_ack = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (n != 6 || if_o.step !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_len: req cycles %0d step %0d required 6 1", n, if_o.step);
        end
    endtask

    task automatic test_explore();
        logic [7:0] l;
        exp_t       e;
        l = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            l = lfsr_step(l);
            sb.push_back('{act: (l < 8'hFF) ? l[1:0] : 2'd3, step: 8'(i)});
        end
        if_x.start = 1'b1;
        @(negedge clk);
        if_x.start = 1'b0;
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            @(negedge clk);
            if (if_x.act_valid) begin
                e = sb.pop_front();
                n_checks++;
                if (if_x.act !== e.act || if_x.step !== e.step) begin
                    n_fail++;
                    $display("FAIL explore_act: act %0d step %0d required %0d %0d",
                             if_x.act, if_x.step, e.act, e.step);
                end
            end
        end
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL explore_timeout: %0d moves pending required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_completion();
        int n_chg;
        n_chg = 0;
        if_c.start = 1'b1;
        @(negedge clk);
        if_c.start = 1'b0;
        if (if_c.change_iteration) n_chg++;
        for (int c = 0; c < 60 && !if_c.done; c++) begin
            @(negedge clk);
            if (if_c.change_iteration) n_chg++;
        end
        n_checks++;
        if (if_c.done !== 1'b1 || if_c.busy !== 1'b0 || if_c.episode !== 8'd2 || n_chg != 3) begin
            n_fail++;
            $display("FAIL completion: done %b busy %b episode %0d restarts %0d required 1 0 2 3",
                     if_c.done, if_c.busy, if_c.episode, n_chg);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (if_c.done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_hold: done %b required 1", if_c.done);
        end
        if_c.upd_ack = 1'b0;
        if_c.start   = 1'b1;
        @(negedge clk);
        if_c.start = 1'b0;
        n_checks++;
        if (if_c.change_iteration !== 1'b1 || if_c.episode !== 8'd0 || if_c.done !== 1'b0 || if_c.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun: chg %b episode %0d done %b busy %b required 1 0 0 1",
                     if_c.change_iteration, if_c.episode, if_c.done, if_c.busy);
        end
        for (int c = 0; c < 10 && !if_c.upd_req; c++) @(negedge clk);
        n_checks++;
        if (if_c.upd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_update: upd_req %b required 1", if_c.upd_req);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (if_c.upd_req !== 1'b0 || if_c.busy !== 1'b0 || if_c.act_valid !== 1'b0 || if_c.done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: req %b busy %b act_valid %b done %b required 0 0 0 0",
                     if_c.upd_req, if_c.busy, if_c.act_valid, if_c.done);
        end
        @(negedge clk);
        rst = 1'b1;
        if_c.upd_ack = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (if_c.busy !== 1'b0 || if_c.done !== 1'b0 || if_c.upd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_pulse: busy %b done %b req %b required 0 0 0",
                     if_c.busy, if_c.done, if_c.upd_req);
        end
    endtask

    initial begin
        test_reset();
        test_start_timing();
        test_greedy_path();
        test_goal();
        test_ack_stall();
        test_explore();
        test_completion();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
